// File: rtl/control_sequencer_pkg.sv
// Shared opcodes, state encodings and instruction field layout for the accumulator CPU sequencer.
package control_sequencer_pkg;

  localparam int unsigned OPC_W = 6;
  localparam int unsigned K_W   = 8;
  localparam int unsigned K_LSB = 0;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_NOP   = 6'h00;
  localparam opcode_t OP_LDA   = 6'h01;
  localparam opcode_t OP_LDB   = 6'h02;
  localparam opcode_t OP_STA   = 6'h03;
  localparam opcode_t OP_STB   = 6'h04;
  localparam opcode_t OP_ADDA  = 6'h05;
  localparam opcode_t OP_ADDB  = 6'h06;
  localparam opcode_t OP_SUBA  = 6'h07;
  localparam opcode_t OP_SUBB  = 6'h08;
  localparam opcode_t OP_ANDA  = 6'h09;
  localparam opcode_t OP_ANDB  = 6'h0A;
  localparam opcode_t OP_ORA   = 6'h0B;
  localparam opcode_t OP_ORB   = 6'h0C;
  localparam opcode_t OP_ADDCA = 6'h0D;
  localparam opcode_t OP_ADDCB = 6'h0E;
  localparam opcode_t OP_SUBCA = 6'h0F;
  localparam opcode_t OP_SUBCB = 6'h10;
  localparam opcode_t OP_ANDCA = 6'h11;
  localparam opcode_t OP_ANDCB = 6'h12;
  localparam opcode_t OP_ORCA  = 6'h13;
  localparam opcode_t OP_ORCB  = 6'h14;
  localparam opcode_t OP_LDCA  = 6'h15;
  localparam opcode_t OP_LDCB  = 6'h16;
  localparam opcode_t OP_ASLA  = 6'h17;
  localparam opcode_t OP_ASRA  = 6'h18;
  localparam opcode_t OP_JMP   = 6'h20;
  localparam opcode_t OP_BEQ   = 6'h21;
  localparam opcode_t OP_BNE   = 6'h22;
  localparam opcode_t OP_BCS   = 6'h23;
  localparam opcode_t OP_BCC   = 6'h24;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_MEMRD  = 2'd2,
    S_EXEC   = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    BrAlways = 3'd0,
    BrZ      = 3'd1,
    BrNz     = 3'd2,
    BrC      = 3'd3,
    BrNc     = 3'd4
  } br_cond_e;

  typedef struct packed {
    logic     is_mem;
    logic     is_const;
    logic     tgt_b;
    logic     wr_reg;
    logic     is_store;
    logic     is_branch;
    br_cond_e br_cond;
  } dec_t;

endpackage

// File: rtl/control_sequencer_decode.sv
// Opcode classifier: which operand source, target register and flow-control condition apply.
module seq_decode
  import control_sequencer_pkg::*;
(
  input  opcode_t opcode,
  output dec_t    dec
);

  always_comb begin
    dec         = '0;
    dec.br_cond = BrAlways;
    unique case (opcode)
      OP_LDA, OP_ADDA, OP_SUBA, OP_ANDA, OP_ORA: begin
        dec.is_mem = 1'b1;
        dec.wr_reg = 1'b1;
      end
      OP_LDB, OP_ADDB, OP_SUBB, OP_ANDB, OP_ORB: begin
        dec.is_mem = 1'b1;
        dec.wr_reg = 1'b1;
        dec.tgt_b  = 1'b1;
      end
      OP_ADDCA, OP_SUBCA, OP_ANDCA, OP_ORCA, OP_LDCA: begin
        dec.is_const = 1'b1;
        dec.wr_reg   = 1'b1;
      end
      OP_ADDCB, OP_SUBCB, OP_ANDCB, OP_ORCB, OP_LDCB: begin
        dec.is_const = 1'b1;
        dec.wr_reg   = 1'b1;
        dec.tgt_b    = 1'b1;
      end
      OP_ASLA, OP_ASRA: dec.wr_reg = 1'b1;
      OP_STA: dec.is_store = 1'b1;
      OP_STB: begin
        dec.is_store = 1'b1;
        dec.tgt_b    = 1'b1;
      end
      OP_JMP: dec.is_branch = 1'b1;
      OP_BEQ: begin
        dec.is_branch = 1'b1;
        dec.br_cond   = BrZ;
      end
      OP_BNE: begin
        dec.is_branch = 1'b1;
        dec.br_cond   = BrNz;
      end
      OP_BCS: begin
        dec.is_branch = 1'b1;
        dec.br_cond   = BrC;
      end
      OP_BCC: begin
        dec.is_branch = 1'b1;
        dec.br_cond   = BrNc;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/memory-read/execute sequencer for the 8-bit accumulator CPU; drives the external ALU.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iEnable,
  output logic [PC_W-1:0]    oIAddr,
  input  logic [INSTR_W-1:0] iInstr,
  output logic [7:0]         oDAddr,
  output logic               oDWE,
  output logic [DATA_W-1:0]  oDData,
  input  logic [DATA_W-1:0]  iDData,
  output logic [5:0]         oAluOp,
  output logic [DATA_W-1:0]  oAluIn1,
  output logic [DATA_W-1:0]  oAluIn2,
  input  logic [8:0]         iAluOut,
  output logic [DATA_W-1:0]  oRegA,
  output logic [DATA_W-1:0]  oRegB,
  output logic               oCarry,
  output logic               oZero
);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0]  opnd_q, opnd_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic               c_q, c_d, z_q, z_d;

  opcode_t            ir_op, dec_op;
  logic [K_W-1:0]     ir_k, in_k;
  dec_t               dec;
  logic [DATA_W-1:0]  opnd, wr_val;
  logic               is_ld, br_taken, dwe;
  logic               unused_ir;

  assign ir_op     = ir_q[INSTR_W-1 -: OPC_W];
  assign ir_k      = ir_q[K_LSB +: K_W];
  assign in_k      = iInstr[K_LSB +: K_W];
  assign unused_ir = ^ir_q[INSTR_W-OPC_W-1:K_W];

  // In S_DECODE the IR is still loading, so classify straight from the ROM word.
  assign dec_op = (state_q == S_DECODE) ? iInstr[INSTR_W-1 -: OPC_W] : ir_op;

  seq_decode u_decode (
    .opcode (dec_op),
    .dec    (dec)
  );

  assign is_ld = (ir_op == OP_LDA) || (ir_op == OP_LDB);
  assign opnd  = dec.is_const ? DATA_W'(ir_k) : opnd_q;

  always_comb begin
    br_taken = 1'b0;
    unique case (dec.br_cond)
      BrAlways: br_taken = 1'b1;
      BrZ:      br_taken = z_q;
      BrNz:     br_taken = !z_q;
      BrC:      br_taken = c_q;
      BrNc:     br_taken = !c_q;
      default:  br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opnd_d  = opnd_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    z_d     = z_q;
    oAluOp  = OP_NOP;
    oAluIn1 = '0;
    oAluIn2 = '0;
    oDAddr  = ir_k;
    oDData  = DATA_W'(iAluOut[7:0]);
    wr_val  = '0;
    dwe     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (iEnable) state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = iInstr;
        oDAddr  = in_k;
        state_d = dec.is_mem ? S_MEMRD : S_EXEC;
      end
      S_MEMRD: begin
        opnd_d  = iDData;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (dec.wr_reg || dec.is_store) oAluOp = ir_op;

        if (ir_op == OP_LDCA) begin
          oAluIn1 = DATA_W'(ir_k);
        end else if (ir_op == OP_LDCB) begin
          oAluIn2 = DATA_W'(ir_k);
        end else if (dec.is_store) begin
          if (dec.tgt_b) oAluIn2 = b_q;
          else           oAluIn1 = a_q;
        end else if ((ir_op == OP_ASLA) || (ir_op == OP_ASRA)) begin
          oAluIn1 = a_q;
        end else if (dec.wr_reg && dec.tgt_b) begin
          // B-side ops put the operand first so the ALU yields B - opnd for SUBB.
          oAluIn1 = opnd;
          oAluIn2 = b_q;
        end else if (dec.wr_reg) begin
          oAluIn1 = a_q;
          oAluIn2 = opnd;
        end

        if (dec.wr_reg) begin
          wr_val = is_ld ? opnd_q : DATA_W'(iAluOut[7:0]);
          c_d    = is_ld ? 1'b0 : iAluOut[8];
          z_d    = (wr_val == '0);
          if (dec.tgt_b) b_d = wr_val;
          else           a_d = wr_val;
        end

        dwe  = dec.is_store;
        pc_d = (dec.is_branch && br_taken) ? PC_W'(ir_k) : pc_q + PC_W'(1);
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      opnd_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opnd_q  <= opnd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  // A store caught by reset in its execute cycle must not reach memory.
  assign oDWE   = dwe & Reset;
  assign oIAddr = pc_q;
  assign oRegA  = a_q;
  assign oRegB  = b_q;
  assign oCarry = c_q;
  assign oZero  = z_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: ROM, data memory and ALU models around control_sequencer, one instruction per step.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  iaddr;
  logic [15:0] instr;
  logic [7:0]  daddr;
  logic        dwe;
  logic [7:0]  dout;
  logic [7:0]  din;
  logic [5:0]  alu_op;
  logic [7:0]  alu_in1, alu_in2;
  logic [8:0]  alu_out;
  logic [7:0]  reg_a, reg_b;
  logic        carry, zero;

  logic [15:0] rom  [256];
  logic [7:0]  dmem [256];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          dwe_cnt  = 0;
  logic [7:0]  dwe_addr, dwe_data;
  int          cnt0;

  always #5 clk = ~clk;

  control_sequencer #(
    .PC_W    (8),
    .DATA_W  (8),
    .INSTR_W (16)
  ) dut (
    .Clock   (clk),
    .Reset   (rst_n),
    .iEnable (en),
    .oIAddr  (iaddr),
    .iInstr  (instr),
    .oDAddr  (daddr),
    .oDWE    (dwe),
    .oDData  (dout),
    .iDData  (din),
    .oAluOp  (alu_op),
    .oAluIn1 (alu_in1),
    .oAluIn2 (alu_in2),
    .iAluOut (alu_out),
    .oRegA   (reg_a),
    .oRegB   (reg_b),
    .oCarry  (carry),
    .oZero   (zero)
  );

  // Registered ROM and data memory: read data is valid the cycle after the address.
  always @(posedge clk) begin
    instr <= rom[iaddr];
    din   <= dmem[daddr];
    if (dwe) dmem[daddr] <= dout;
  end

  function automatic logic [8:0] alu_model(input logic [5:0] op, input logic [7:0] x,
                                           input logic [7:0] y);
    case (op)
      OP_ADDA, OP_ADDCA, OP_ADDB, OP_ADDCB: return {1'b0, x} + {1'b0, y};
      OP_SUBA, OP_SUBCA:                    return {1'b0, x} - {1'b0, y};
      OP_SUBB, OP_SUBCB:                    return {1'b0, y} - {1'b0, x};
      OP_ANDA, OP_ANDCA, OP_ANDB, OP_ANDCB: return {1'b0, x & y};
      OP_ORA, OP_ORCA, OP_ORB, OP_ORCB:     return {1'b0, x | y};
      OP_LDCA, OP_STA:                      return {1'b0, x};
      OP_LDCB, OP_STB:                      return {1'b0, y};
      OP_ASLA:                              return {x[7], x[6:0], 1'b0};
      OP_ASRA:                              return {x[0], x[7], x[7:1]};
      default:                              return 9'h000;
    endcase
  endfunction

  assign alu_out = alu_model(alu_op, alu_in1, alu_in2);

  always @(negedge clk) begin
    if (dwe === 1'b1) begin
      dwe_cnt++;
      dwe_addr = daddr;
      dwe_data = dout;
    end
  end

  function automatic logic [15:0] ins(input logic [5:0] op, input logic [7:0] k);
    return {op, 2'b00, k};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_regs(input string tag, input logic [7:0] pc, input logic [7:0] a,
                            input logic [7:0] b, input logic c, input logic z);
    check({tag, "_pc"}, iaddr, pc);
    check({tag, "_a"}, reg_a, a);
    check({tag, "_b"}, reg_b, b);
    check({tag, "_c"}, carry, c);
    check({tag, "_z"}, zero, z);
  endtask

  // Let exactly one instruction start, then count edges until the PC moves.
  task automatic exec1(input string tag, input int exp_cyc);
    logic [7:0] old_pc;
    int         cyc;
    @(negedge clk);
    en     = 1'b1;
    old_pc = iaddr;
    @(posedge clk);
    #1;
    en  = 1'b0;
    cyc = 1;
    while (iaddr == old_pc && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_cyc"}, cyc, exp_cyc);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i]  = ins(OP_NOP, 8'h00);
      dmem[i] = 8'h00;
    end
    dmem[8'h10] = 8'h05;
    dmem[8'h11] = 8'h07;

    rom[8'h00] = ins(OP_LDCA, 8'h7F);
    rom[8'h01] = ins(OP_ADDCA, 8'h01);
    rom[8'h02] = ins(OP_ADDCA, 8'h80);
    rom[8'h03] = ins(OP_BEQ, 8'h40);
    rom[8'h40] = ins(OP_BNE, 8'h10);
    rom[8'h41] = ins(OP_LDCA, 8'h3C);
    rom[8'h42] = ins(OP_LDB, 8'h10);
    rom[8'h43] = ins(OP_SUBB, 8'h11);
    rom[8'h44] = ins(OP_STA, 8'h20);
    rom[8'h45] = ins(OP_BCS, 8'h50);
    rom[8'h50] = ins(OP_BCC, 8'h00);
    rom[8'h51] = ins(OP_JMP, 8'hFF);
    rom[8'hFF] = ins(OP_NOP, 8'h00);

    rst_n = 1'b0;
    en    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_regs("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    check("reset_dwe", dwe, 1'b0);

    exec1("ldca7f", 3);
    check_regs("ldca7f", 8'h01, 8'h7F, 8'h00, 1'b0, 1'b0);
    exec1("addc01", 3);
    check_regs("addc01", 8'h02, 8'h80, 8'h00, 1'b0, 1'b0);
    exec1("addc80", 3);
    check_regs("addc80", 8'h03, 8'h00, 8'h00, 1'b1, 1'b1);

    exec1("beq", 3);
    check("beq_pc", iaddr, 8'h40);
    exec1("bne", 3);
    check_regs("bne", 8'h41, 8'h00, 8'h00, 1'b1, 1'b1);

    exec1("ldca3c", 3);
    check_regs("ldca3c", 8'h42, 8'h3C, 8'h00, 1'b0, 1'b0);
    exec1("ldb", 4);
    check_regs("ldb", 8'h43, 8'h3C, 8'h05, 1'b0, 1'b0);
    exec1("subb", 4);
    check_regs("subb", 8'h44, 8'h3C, 8'hFE, 1'b1, 1'b0);

    cnt0 = dwe_cnt;
    exec1("sta", 3);
    check_regs("sta", 8'h45, 8'h3C, 8'hFE, 1'b1, 1'b0);
    check("sta_dwe_pulses", dwe_cnt - cnt0, 1);
    check("sta_daddr", dwe_addr, 8'h20);
    check("sta_ddata", dwe_data, 8'h3C);
    check("sta_mem", dmem[8'h20], 8'h3C);

    exec1("bcs", 3);
    check("bcs_pc", iaddr, 8'h50);
    exec1("bcc", 3);
    check("bcc_pc", iaddr, 8'h51);
    exec1("jmp", 3);
    check("jmp_pc", iaddr, 8'hFF);
    exec1("nop_wrap", 3);
    check_regs("nop_wrap", 8'h00, 8'h3C, 8'hFE, 1'b1, 1'b0);

    rom[8'h00] = ins(OP_ADDA, 8'h10);
    rom[8'h01] = ins(OP_ASLA, 8'h00);
    rom[8'h02] = 16'hFC00;

    // Abandon an ADDA in its memory-read cycle.
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    cnt0  = dwe_cnt;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_regs("midreset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    check("midreset_dwe", dwe_cnt - cnt0, 0);

    exec1("adda", 4);
    check_regs("adda", 8'h01, 8'h05, 8'h00, 1'b0, 1'b0);
    exec1("asla", 3);
    check_regs("asla", 8'h02, 8'h0A, 8'h00, 1'b0, 1'b0);
    exec1("unknown", 3);
    check_regs("unknown", 8'h03, 8'h0A, 8'h00, 1'b0, 1'b0);
    check("total_dwe", dwe_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
